// File: rtl/ad_ip_jesd204_tpl_adc_pn_mon.sv
// ad_ip_jesd204_tpl_adc_pn_mon
// Per-channel PN7/PN15 monitor for the JESD204 ADC transport layer.
// Every valid beat is compared against the sequence continued from the
// previous valid beat, so the checker needs no seed. A mismatch only counts
// towards pn_err while the monitor is in sync.
//
// Optional feature: define AD_IP_JESD204_TPL_ADC_PN_ERR_COUNT_EN to build a
// saturating 32-bit mismatch counter on pn_err_count. Without it the port is
// tied to zero.
//
// Beat interface: adc_valid qualifies adc_data/pn_sel in the same cycle. There
// is no ready; the monitor accepts every beat, and cycles with adc_valid low
// are ignored entirely.
module ad_ip_jesd204_tpl_adc_pn_mon #(
    parameter int DATA_PATH_WIDTH      = 4,
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int LOCK_COUNT           = 16,
    parameter int OOS_THRESHOLD        = 4
) (
    input  logic                                            clk,
    input  logic                                            resetn,
    input  logic                                            adc_valid,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] adc_data,
    input  logic                                            pn_sel,
    input  logic                                            pn_err_clr,
    output logic                                            pn_oos,
    output logic                                            pn_err,
    output logic [31:0]                                     pn_err_count
);

    localparam int DW = DATA_PATH_WIDTH * CONVERTER_RESOLUTION;
    localparam logic [7:0] LOCK_C = 8'(LOCK_COUNT);
    localparam logic [7:0] OOS_C  = 8'(OOS_THRESHOLD);

    // Two states; pn_oos is a direct decode of the state register so the
    // FSM state is always visible at the port.
    typedef enum logic {
        ST_OOS  = 1'b0,
        ST_SYNC = 1'b1
    } state_t;

    // Stream position i (0 = first bit on the wire) lives in sample i/CR,
    // MSB first inside the sample.
    function automatic int stream_pos(input int i);
        return (i / CONVERTER_RESOLUTION) * CONVERTER_RESOLUTION
             + (CONVERTER_RESOLUTION - 1 - (i % CONVERTER_RESOLUTION));
    endfunction

    // Continue the stream of the previous beat by DW bits. Only the last 7/15
    // bits of prev actually influence the result (they are the LFSR seed).
    function automatic logic [DW-1:0] pn_predict(input logic [DW-1:0] prev,
                                                 input logic          sel);
        logic [2*DW-1:0] st;
        logic [DW-1:0]   pred;
        st   = '0;
        pred = '0;
        for (int i = 0; i < DW; i++) begin
            st[i] = prev[stream_pos(i)];
        end
        for (int i = DW; i < 2 * DW; i++) begin
            st[i] = sel ? (st[i-14] ^ st[i-15]) : (st[i-6] ^ st[i-7]);
        end
        for (int i = 0; i < DW; i++) begin
            pred[stream_pos(i)] = st[DW+i];
        end
        return pred;
    endfunction

    logic          s1_valid;
    logic [DW-1:0] s1_data;
    logic          s1_sel;

    state_t        state_q, state_d;
    logic [7:0]    match_q, match_d;
    logic [7:0]    miss_q, miss_d;
    logic [DW-1:0] prev_q, prev_d;
    logic          have_q, have_d;
    logic          sel_q, sel_d;
    logic          err_q, err_d;
    logic [DW-1:0] predicted;
    logic          beat_match;
    logic          err_set;

    // Stage 1: register the incoming beat and its sequence select.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_sel   <= 1'b0;
        end else begin
            s1_valid <= adc_valid;
            s1_data  <= adc_data;
            s1_sel   <= pn_sel;
        end
    end

    // Stage 2 next-state: compare, count, and decide lock / loss of lock.
    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        miss_d     = miss_q;
        prev_d     = prev_q;
        have_d     = have_q;
        sel_d      = sel_q;
        err_set    = 1'b0;
        predicted  = pn_predict(prev_q, s1_sel);
        beat_match = (s1_data == predicted) && (s1_data != '0);

        if (s1_valid) begin
            // Every valid beat becomes the reference for the next one.
            prev_d = s1_data;
            sel_d  = s1_sel;
            have_d = 1'b1;
            if (s1_sel != sel_q) begin
                // New sequence: drop lock, this beat is only a seed.
                state_d = ST_OOS;
                match_d = '0;
                miss_d  = '0;
            end else if (have_q) begin
                case (state_q)
                    ST_OOS: begin
                        if (beat_match) begin
                            if (match_q >= LOCK_C - 8'd1) begin
                                match_d = LOCK_C;
                                miss_d  = '0;
                                state_d = ST_SYNC;
                            end else begin
                                match_d = match_q + 8'd1;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                    ST_SYNC: begin
                        if (!beat_match) begin
                            err_set = 1'b1;
                            if (miss_q >= OOS_C - 8'd1) begin
                                miss_d  = OOS_C;
                                match_d = '0;
                                state_d = ST_OOS;
                            end else begin
                                miss_d = miss_q + 8'd1;
                            end
                        end else begin
                            miss_d = '0;
                        end
                    end
                    default: state_d = ST_OOS;
                endcase
            end
        end

        // A new error beats a simultaneous clear.
        if (err_set) begin
            err_d = 1'b1;
        end else if (pn_err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Stage 2 registers: FSM state, counters and the previous-beat reference.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_OOS;
            match_q <= '0;
            miss_q  <= '0;
            prev_q  <= '0;
            have_q  <= 1'b0;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            prev_q  <= prev_d;
            have_q  <= have_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    assign pn_oos = (state_q == ST_OOS);
    assign pn_err = err_q;

`ifdef AD_IP_JESD204_TPL_ADC_PN_ERR_COUNT_EN
    logic [31:0] err_cnt_q;

    // Saturating count of in-sync mismatches; clear has priority.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_cnt_q <= '0;
        end else if (pn_err_clr) begin
            err_cnt_q <= '0;
        end else if (err_set && (err_cnt_q != 32'hFFFF_FFFF)) begin
            err_cnt_q <= err_cnt_q + 32'd1;
        end
    end

    assign pn_err_count = err_cnt_q;
`else
    assign pn_err_count = '0;
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_mon.sv
// Testbench for ad_ip_jesd204_tpl_adc_pn_mon (default parameters).
// Reference model: PN streams are produced bit by bit from the generator
// recurrence, and a beat is judged good when every one of its bits obeys the
// recurrence over the concatenated previous+current bit stream.
module tb_ad_ip_jesd204_tpl_adc_pn_mon;

    localparam int LOCK = 16;
    localparam int THR  = 4;
`ifdef AD_IP_JESD204_TPL_ADC_PN_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        adc_valid;
    logic [63:0] adc_data;
    logic        pn_sel;
    logic        pn_err_clr;
    logic        pn_oos;
    logic        pn_err;
    logic [31:0] pn_err_count;

    int total = 0;
    int bad   = 0;

    // model state
    bit          m_oos, m_err, m_have, m_sel;
    int          m_match, m_miss;
    logic [31:0] m_cnt;
    logic [63:0] m_prev;
    // what the DUT's first stage holds
    bit          d1_valid, d1_sel;
    logic [63:0] d1_data;
    // scoreboard: {oos, err, count}
    logic [33:0] exp_q[$];
    // generator bit history, newest at the back
    bit          gq[$];

    ad_ip_jesd204_tpl_adc_pn_mon #(
        .DATA_PATH_WIDTH(4),
        .CONVERTER_RESOLUTION(16),
        .LOCK_COUNT(LOCK),
        .OOS_THRESHOLD(THR)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .adc_valid(adc_valid),
        .adc_data(adc_data),
        .pn_sel(pn_sel),
        .pn_err_clr(pn_err_clr),
        .pn_oos(pn_oos),
        .pn_err(pn_err),
        .pn_err_count(pn_err_count)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pn_ok(input logic [63:0] prev, input logic [63:0] cur, input bit s);
        bit st[128];
        if (cur == 64'd0) return 1'b0;
        for (int smp = 0; smp < 4; smp++) begin
            for (int b = 0; b < 16; b++) begin
                st[smp*16 + 15 - b]      = prev[smp*16 + b];
                st[64 + smp*16 + 15 - b] = cur[smp*16 + b];
            end
        end
        for (int k = 64; k < 128; k++) begin
            if (s) begin
                if (st[k] != (st[k-14] ^ st[k-15])) return 1'b0;
            end else begin
                if (st[k] != (st[k-6] ^ st[k-7])) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_oos = 1'b1; m_err = 1'b0; m_have = 1'b0; m_sel = 1'b0;
        m_match = 0; m_miss = 0; m_cnt = '0; m_prev = '0;
        d1_valid = 1'b0; d1_sel = 1'b0; d1_data = '0;
        exp_q.delete();
    endtask

    // Model of one clock edge acting on the beat seen one cycle earlier.
    task automatic model_edge(input bit v, input logic [63:0] d, input bit s, input bit clr);
        bit set;
        bit mt;
        logic [31:0] ec;
        set = 1'b0;
        if (v) begin
            if (s != m_sel) begin
                m_oos = 1'b1; m_match = 0; m_miss = 0;
            end else if (m_have) begin
                mt = pn_ok(m_prev, d, s);
                if (m_oos) begin
                    if (mt) begin
                        m_match++;
                        if (m_match >= LOCK) begin m_oos = 1'b0; m_miss = 0; end
                    end else begin
                        m_match = 0;
                    end
                end else begin
                    if (!mt) begin
                        set = 1'b1;
                        m_miss++;
                        if (m_miss >= THR) begin m_oos = 1'b1; m_match = 0; end
                    end else begin
                        m_miss = 0;
                    end
                end
            end
            m_prev = d; m_sel = s; m_have = 1'b1;
        end
        if (set) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        if (clr) m_cnt = '0;
        else if (set && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        ec = CNT_EN ? m_cnt : 32'd0;
        exp_q.push_back({m_oos, m_err, ec});
    endtask

    task automatic check_outputs();
        logic [33:0] e;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        check("oos", 32'(pn_oos), 32'(e[33]));
        check("err", 32'(pn_err), 32'(e[32]));
        check("err_count", pn_err_count, e[31:0]);
    endtask

    // driver: one cycle
    task automatic step(input bit v, input logic [63:0] d, input bit s, input bit clr);
        adc_valid = v; adc_data = d; pn_sel = s; pn_err_clr = clr;
        @(posedge clk);
        model_edge(d1_valid, d1_data, d1_sel, clr);
        d1_valid = v; d1_data = d; d1_sel = s;
        #1;
        check_outputs();
    endtask

    task automatic gen_seed();
        gq.delete();
        for (int i = 0; i < 14; i++) gq.push_back(1'($urandom_range(0, 1)));
        gq.push_back(1'b1);
    endtask

    task automatic gen_beat(input bit s, output logic [63:0] d);
        bit nb;
        d = '0;
        for (int smp = 0; smp < 4; smp++) begin
            for (int b = 15; b >= 0; b--) begin
                nb = s ? (gq[gq.size()-14] ^ gq[gq.size()-15])
                       : (gq[gq.size()-6] ^ gq[gq.size()-7]);
                gq.push_back(nb);
                void'(gq.pop_front());
                d[smp*16 + b] = nb;
            end
        end
    endtask

    task automatic run_stream(input int n, input bit s);
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            gen_beat(s, d);
            step(1'b1, d, s, 1'b0);
        end
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] rd;
        bit cur_sel;
        bit v;
        bit clr;

        // reset
        resetn = 1'b0; adc_valid = 1'b0; adc_data = '0; pn_sel = 1'b0; pn_err_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_oos", 32'(pn_oos), 32'd1);
        check("rst_err", 32'(pn_err), 32'd0);
        check("rst_cnt", pn_err_count, 32'd0);
        resetn = 1'b1;

        // PN15 lock: seed + 16 matches, visible two edges after beat 17
        gen_seed();
        run_stream(17, 1'b1);
        check("lock15_pre", 32'(pn_oos), 32'd1);
        run_stream(1, 1'b1);
        check("lock15", 32'(pn_oos), 32'd0);
        check("lock15_err", 32'(pn_err), 32'd0);

        // one corrupted seed-window bit -> two mismatches, stays locked
        gen_beat(1'b1, d);
        step(1'b1, d ^ (64'd1 << 51), 1'b1, 1'b0);
        run_stream(4, 1'b1);
        check("flip_err", 32'(pn_err), 32'd1);
        check("flip_oos", 32'(pn_oos), 32'd0);
        check("flip_cnt", pn_err_count, CNT_EN ? 32'd2 : 32'd0);

        // clear, then clear coinciding with a mismatch
        gen_beat(1'b1, d);
        step(1'b1, d, 1'b1, 1'b1);
        check("clr_err", 32'(pn_err), 32'd0);
        check("clr_cnt", pn_err_count, 32'd0);
        gen_beat(1'b1, d);
        step(1'b1, d ^ (64'd1 << 51), 1'b1, 1'b0);
        gen_beat(1'b1, d);
        step(1'b1, d, 1'b1, 1'b1);
        check("clr_vs_set", 32'(pn_err), 32'd1);
        run_stream(4, 1'b1);
        check("clr_vs_set_cnt", pn_err_count, CNT_EN ? 32'd1 : 32'd0);
        check("clr_vs_set_oos", 32'(pn_oos), 32'd0);

        // four all-zero beats drop lock
        for (int i = 0; i < 4; i++) step(1'b1, 64'd0, 1'b1, 1'b0);
        run_stream(1, 1'b1);
        check("zeros_oos", 32'(pn_oos), 32'd1);
        check("zeros_err", 32'(pn_err), 32'd1);
        run_stream(19, 1'b1);
        check("relock_zero", 32'(pn_oos), 32'd0);

        // switch to PN7 while locked on PN15
        gen_seed();
        run_stream(2, 1'b0);
        check("sel_oos", 32'(pn_oos), 32'd1);
        check("sel_err_kept", 32'(pn_err), 32'd1);
        run_stream(15, 1'b0);
        check("sel_relock_pre", 32'(pn_oos), 32'd1);
        run_stream(1, 1'b0);
        check("sel_relock", 32'(pn_oos), 32'd0);
        check("sel_relock_err", 32'(pn_err), 32'd1);

        // asynchronous reset while locked
        #2 resetn = 1'b0;
        #1;
        check("async_oos", 32'(pn_oos), 32'd1);
        check("async_err", 32'(pn_err), 32'd0);
        check("async_cnt", pn_err_count, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;

        // PN7 with a gap after every valid beat
        gen_seed();
        for (int i = 0; i < 17; i++) begin
            gen_beat(1'b0, d);
            step(1'b1, d, 1'b0, 1'b0);
            rd = {$urandom, $urandom};
            step(1'b0, rd, 1'b0, 1'b0);
        end
        check("gap_lock", 32'(pn_oos), 32'd0);
        check("gap_err", 32'(pn_err), 32'd0);

        // random traffic
        cur_sel = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                cur_sel = ~cur_sel;
                gen_seed();
            end
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            if (v) begin
                gen_beat(cur_sel, d);
                if ($urandom_range(0, 19) == 0) d = d ^ (64'd1 << $urandom_range(0, 63));
                if ($urandom_range(0, 59) == 0) d = 64'd0;
            end else begin
                d = {$urandom, $urandom};
            end
            step(v, d, cur_sel, clr);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 64'd0, cur_sel, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
